// File: rtl/prt_dptx_pkg.sv
// Shared types and constants for the DP TX link bring-up sequencer.
package prt_dptx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CR       = 3'd1,
        ST_EQ       = 3'd2,
        ST_IDLE_PAT = 3'd3,
        ST_VID      = 3'd4
    } lnk_seq_sta_t;

    localparam logic [1:0] P_TPS_NONE = 2'd0;
    localparam logic [1:0] P_TPS1     = 2'd1;
    localparam logic [1:0] P_TPS2     = 2'd2;
    localparam logic [1:0] P_TPS3     = 2'd3;

    typedef struct packed {
        logic       trn_sel;
        logic [1:0] tps;
        logic       scrm_en;
        logic       vid_en;
    } lnk_ctl_t;

    // Link control word presented while sitting in state s.
    function automatic lnk_ctl_t ctl_for(lnk_seq_sta_t s, logic tps3);
        lnk_ctl_t c;
        c = '0;
        case (s)
            ST_CR: begin
                c.trn_sel = 1'b1;
                c.tps     = P_TPS1;
            end
            ST_EQ: begin
                c.trn_sel = 1'b1;
                c.tps     = tps3 ? P_TPS3 : P_TPS2;
            end
            ST_IDLE_PAT: begin
                c.scrm_en = 1'b1;
            end
            ST_VID: begin
                c.scrm_en = 1'b1;
                c.vid_en  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/prt_dptx_lnk_seq.sv
// DP TX link bring-up sequencer: CR training, EQ training, idle pattern,
// then active video. Abortable by STOP, restartable by START, and each
// training phase is bounded by a timeout.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | link off, waiting for START
// CR       | clock-recovery training, TPS1
// EQ       | channel equalisation, TPS2 or TPS3
// IDLE_PAT | scrambled idle pattern, counting BS strobes
// VID      | active video
module prt_dptx_lnk_seq
    import prt_dptx_pkg::*;
#(
    parameter int P_TMR_W   = 24,
    parameter int P_TMO     = 1_000_000,
    parameter int P_IDLE_BS = 8
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       CMD_START_IN,
    input  logic       CMD_NEXT_IN,
    input  logic       CMD_STOP_IN,
    input  logic       CMD_LANES_IN,
    input  logic       CMD_TPS3_IN,
    input  logic       LNK_BS_IN,
    output logic       CTL_LANES_OUT,
    output logic       CTL_TRN_SEL_OUT,
    output logic [1:0] CTL_TPS_OUT,
    output logic       CTL_SCRM_EN_OUT,
    output logic       CTL_VID_EN_OUT,
    output logic [2:0] STA_STATE_OUT,
    output logic       STA_BUSY_OUT,
    output logic       STA_TMO_OUT
);

    localparam logic [P_TMR_W-1:0] TMR_LAST = P_TMR_W'(P_TMO - 1);
    localparam logic [7:0]         BS_LAST  = 8'(P_IDLE_BS - 1);

    lnk_seq_sta_t       state;
    lnk_seq_sta_t       nxt;
    lnk_ctl_t           ctl;
    logic               lanes;
    logic               tps3;
    logic               tmo;
    logic               busy;
    logic [P_TMR_W-1:0] tmr;
    logic [7:0]         bs_cnt;
    logic               accept_start;
    logic               tmo_hit;
    logic               nxt_tps3;

    // Next-state decode: STOP beats START, START beats NEXT/timeout,
    // and NEXT beats a timeout landing on the same cycle.
    always_comb begin
        nxt          = state;
        accept_start = 1'b0;
        tmo_hit      = 1'b0;
        if (CMD_STOP_IN) begin
            nxt = ST_IDLE;
        end else if (CMD_START_IN) begin
            nxt          = ST_CR;
            accept_start = 1'b1;
        end else begin
            case (state)
                ST_CR: begin
                    if (CMD_NEXT_IN) begin
                        nxt = ST_EQ;
                    end else if (tmr == TMR_LAST) begin
                        nxt     = ST_IDLE;
                        tmo_hit = 1'b1;
                    end
                end
                ST_EQ: begin
                    if (CMD_NEXT_IN) begin
                        nxt = ST_IDLE_PAT;
                    end else if (tmr == TMR_LAST) begin
                        nxt     = ST_IDLE;
                        tmo_hit = 1'b1;
                    end
                end
                ST_IDLE_PAT: begin
                    if (LNK_BS_IN && bs_cnt == BS_LAST) nxt = ST_VID;
                end
                ST_IDLE, ST_VID: nxt = state;
                default:         nxt = ST_IDLE;
            endcase
        end
        nxt_tps3 = accept_start ? CMD_TPS3_IN : tps3;
    end

    // State, latched command options, timer, BS counter and registered outputs.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state  <= ST_IDLE;
            ctl    <= '0;
            lanes  <= 1'b0;
            tps3   <= 1'b0;
            tmo    <= 1'b0;
            busy   <= 1'b0;
            tmr    <= '0;
            bs_cnt <= '0;
        end else begin
            state <= nxt;
            ctl   <= ctl_for(nxt, nxt_tps3);
            busy  <= (nxt != ST_IDLE);

            if (accept_start) begin
                lanes <= CMD_LANES_IN;
                tps3  <= CMD_TPS3_IN;
                tmo   <= 1'b0;
            end else if (tmo_hit) begin
                tmo <= 1'b1;
            end

            if (accept_start || (state == ST_CR && nxt == ST_EQ)) begin
                tmr <= '0;
            end else if ((state == ST_CR || state == ST_EQ) && tmr != TMR_LAST) begin
                tmr <= tmr + P_TMR_W'(1);
            end

            if (state == ST_EQ && nxt == ST_IDLE_PAT) begin
                bs_cnt <= '0;
            end else if (state == ST_IDLE_PAT && LNK_BS_IN && bs_cnt != 8'hFF) begin
                bs_cnt <= bs_cnt + 8'd1;
            end
        end
    end

    assign CTL_LANES_OUT   = lanes;
    assign CTL_TRN_SEL_OUT = ctl.trn_sel;
    assign CTL_TPS_OUT     = ctl.tps;
    assign CTL_SCRM_EN_OUT = ctl.scrm_en;
    assign CTL_VID_EN_OUT  = ctl.vid_en;
    assign STA_STATE_OUT   = state;
    assign STA_BUSY_OUT    = busy;
    assign STA_TMO_OUT     = tmo;

endmodule

// File: tb/tb_prt_dptx_lnk_seq.sv
// Scoreboard bench for the DP TX link sequencer (timeout shortened to 100).
module tb_prt_dptx_lnk_seq;

    typedef struct packed {
        logic [2:0] st;
        logic       lanes;
        logic       trn;
        logic [1:0] tps;
        logic       scrm;
        logic       vid;
        logic       busy;
        logic       tmo;
    } exp_t;

    // Input vector bits: {start, next, stop, lanes, tps3, bs}
    localparam logic [5:0] I_NONE  = 6'b000000;
    localparam logic [5:0] I_START = 6'b100000;
    localparam logic [5:0] I_NEXT  = 6'b010000;
    localparam logic [5:0] I_STOP  = 6'b001000;
    localparam logic [5:0] I_LN4   = 6'b000100;
    localparam logic [5:0] I_TPS3  = 6'b000010;
    localparam logic [5:0] I_BS    = 6'b000001;

    logic       CLK_IN = 1'b0;
    logic       RST_IN = 1'b1;
    logic       CMD_START_IN = 1'b0;
    logic       CMD_NEXT_IN = 1'b0;
    logic       CMD_STOP_IN = 1'b0;
    logic       CMD_LANES_IN = 1'b0;
    logic       CMD_TPS3_IN = 1'b0;
    logic       LNK_BS_IN = 1'b0;
    logic       CTL_LANES_OUT;
    logic       CTL_TRN_SEL_OUT;
    logic [1:0] CTL_TPS_OUT;
    logic       CTL_SCRM_EN_OUT;
    logic       CTL_VID_EN_OUT;
    logic [2:0] STA_STATE_OUT;
    logic       STA_BUSY_OUT;
    logic       STA_TMO_OUT;

    int n_vec = 0;
    int n_err = 0;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  aexp_q[$];
    event  async_ev;

    prt_dptx_lnk_seq #(.P_TMR_W(24), .P_TMO(100), .P_IDLE_BS(8)) dut (
        .CLK_IN          (CLK_IN),
        .RST_IN          (RST_IN),
        .CMD_START_IN    (CMD_START_IN),
        .CMD_NEXT_IN     (CMD_NEXT_IN),
        .CMD_STOP_IN     (CMD_STOP_IN),
        .CMD_LANES_IN    (CMD_LANES_IN),
        .CMD_TPS3_IN     (CMD_TPS3_IN),
        .LNK_BS_IN       (LNK_BS_IN),
        .CTL_LANES_OUT   (CTL_LANES_OUT),
        .CTL_TRN_SEL_OUT (CTL_TRN_SEL_OUT),
        .CTL_TPS_OUT     (CTL_TPS_OUT),
        .CTL_SCRM_EN_OUT (CTL_SCRM_EN_OUT),
        .CTL_VID_EN_OUT  (CTL_VID_EN_OUT),
        .STA_STATE_OUT   (STA_STATE_OUT),
        .STA_BUSY_OUT    (STA_BUSY_OUT),
        .STA_TMO_OUT     (STA_TMO_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    // Expected outputs for a state, from the state/output table.
    function automatic exp_t ex(int st, bit lanes, bit tps3, bit tmo);
        exp_t e;
        e.st    = 3'(st);
        e.lanes = lanes;
        e.trn   = (st == 1 || st == 2);
        e.tps   = (st == 1) ? 2'd1 : (st == 2) ? (tps3 ? 2'd3 : 2'd2) : 2'd0;
        e.scrm  = (st == 3 || st == 4);
        e.vid   = (st == 4);
        e.busy  = (st != 0);
        e.tmo   = tmo;
        return e;
    endfunction

    function automatic exp_t snap();
        exp_t a;
        a.st    = STA_STATE_OUT;
        a.lanes = CTL_LANES_OUT;
        a.trn   = CTL_TRN_SEL_OUT;
        a.tps   = CTL_TPS_OUT;
        a.scrm  = CTL_SCRM_EN_OUT;
        a.vid   = CTL_VID_EN_OUT;
        a.busy  = STA_BUSY_OUT;
        a.tmo   = STA_TMO_OUT;
        return a;
    endfunction

    task automatic compare(input exp_t e, input string nm);
        exp_t a;
        a = snap();
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got st=%0d lanes=%0b trn=%0b tps=%0d scrm=%0b vid=%0b busy=%0b tmo=%0b, want st=%0d lanes=%0b trn=%0b tps=%0d scrm=%0b vid=%0b busy=%0b tmo=%0b",
                     nm, a.st, a.lanes, a.trn, a.tps, a.scrm, a.vid, a.busy, a.tmo,
                     e.st, e.lanes, e.trn, e.tps, e.scrm, e.vid, e.busy, e.tmo);
        end
    endtask

    // One cycle of stimulus; the expectation applies after the coming edge.
    task automatic cyc(input logic [5:0] in, input exp_t e, input string nm);
        @(posedge CLK_IN);
        #1;
        CMD_START_IN = in[5];
        CMD_NEXT_IN  = in[4];
        CMD_STOP_IN  = in[3];
        CMD_LANES_IN = in[2];
        CMD_TPS3_IN  = in[1];
        LNK_BS_IN    = in[0];
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Edge monitor: claims the expectation for this edge, checks once settled.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge CLK_IN);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                #3;
                compare(e, nm);
            end
        end
    end

    // Between-edge monitor for asynchronous reset response.
    initial begin
        forever begin
            @(async_ev);
            if (aexp_q.size() > 0) compare(aexp_q.pop_front(), "async_rst");
        end
    end

    initial begin
        // reset
        cyc(I_NONE, ex(0, 0, 0, 0), "rst_hold");
        cyc(I_NONE, ex(0, 0, 0, 0), "rst_hold");
        @(negedge CLK_IN);
        RST_IN = 1'b0;
        cyc(I_NONE, ex(0, 0, 0, 0), "idle_after_rst");

        // 1: full bring-up, 4 lanes, TPS2
        cyc(I_START | I_LN4, ex(1, 1, 0, 0), "t1_start");
        repeat (8) cyc(I_NONE, ex(1, 1, 0, 0), "t1_cr");
        cyc(I_NEXT, ex(2, 1, 0, 0), "t1_eq");
        repeat (9) cyc(I_NONE, ex(2, 1, 0, 0), "t1_eq_hold");
        cyc(I_NEXT, ex(3, 1, 0, 0), "t1_idle_pat");
        for (int p = 1; p <= 8; p++) begin
            cyc(I_BS, ex((p == 8) ? 4 : 3, 1, 0, 0), "t1_bs");
            if (p < 8) cyc(I_NONE, ex(3, 1, 0, 0), "t1_bs_gap");
        end
        cyc(I_NEXT, ex(4, 1, 0, 0), "t1_vid_next_ign");
        cyc(I_BS, ex(4, 1, 0, 0), "t1_vid_bs_ign");

        // 2: retrain from VID with TPS3, 2 lanes; STOP from EQ
        cyc(I_START | I_TPS3, ex(1, 0, 1, 0), "t2_restart");
        cyc(I_NEXT, ex(2, 0, 1, 0), "t2_eq_tps3");
        cyc(I_NONE, ex(2, 0, 1, 0), "t2_eq_hold");
        cyc(I_STOP, ex(0, 0, 1, 0), "t2_stop");

        // 3: CR timeout, ignored inputs in IDLE, START clears flag
        cyc(I_START | I_LN4, ex(1, 1, 0, 0), "t3_start");
        repeat (99) cyc(I_NONE, ex(1, 1, 0, 0), "t3_cr_wait");
        cyc(I_NONE, ex(0, 1, 0, 1), "t3_tmo");
        cyc(I_NEXT, ex(0, 1, 0, 1), "t3_idle_next_ign");
        cyc(I_BS, ex(0, 1, 0, 1), "t3_idle_bs_ign");
        cyc(I_START | I_TPS3, ex(1, 0, 1, 0), "t3_tmo_clr");

        // 5: NEXT on the timeout cycle wins; then EQ timeout
        repeat (99) cyc(I_NONE, ex(1, 0, 1, 0), "t5_cr_wait");
        cyc(I_NEXT, ex(2, 0, 1, 0), "t5_next_wins");
        repeat (99) cyc(I_NONE, ex(2, 0, 1, 0), "t5_eq_wait");
        cyc(I_NONE, ex(0, 0, 1, 1), "t5_eq_tmo");

        // 4: STOP+START in VID, then START alone in VID, STOP+NEXT in CR
        cyc(I_START | I_LN4, ex(1, 1, 0, 0), "t4_start");
        cyc(I_NEXT, ex(2, 1, 0, 0), "t4_eq");
        cyc(I_NEXT, ex(3, 1, 0, 0), "t4_idle_pat");
        repeat (7) cyc(I_BS, ex(3, 1, 0, 0), "t4_bs");
        cyc(I_BS, ex(4, 1, 0, 0), "t4_vid");
        cyc(I_NONE, ex(4, 1, 0, 0), "t4_vid_hold");
        cyc(I_STOP | I_START, ex(0, 1, 0, 0), "t4_stop_pri");
        cyc(I_NONE, ex(0, 1, 0, 0), "t4_idle");
        cyc(I_START | I_LN4, ex(1, 1, 0, 0), "t4_start2");
        cyc(I_NEXT, ex(2, 1, 0, 0), "t4_eq2");
        cyc(I_NEXT, ex(3, 1, 0, 0), "t4_idle_pat2");
        repeat (7) cyc(I_BS, ex(3, 1, 0, 0), "t4_bs2");
        cyc(I_BS, ex(4, 1, 0, 0), "t4_vid2");
        cyc(I_START, ex(1, 0, 0, 0), "t4_restart_lanes");
        cyc(I_STOP | I_NEXT | I_START, ex(0, 0, 0, 0), "t4_stop_next");

        // 6: asynchronous reset mid-EQ
        cyc(I_START | I_LN4 | I_TPS3, ex(1, 1, 1, 0), "t6_start");
        cyc(I_NEXT, ex(2, 1, 1, 0), "t6_eq");
        cyc(I_NONE, ex(2, 1, 1, 0), "t6_eq_hold");
        @(posedge CLK_IN);
        #4;
        RST_IN = 1'b1;
        #1;
        aexp_q.push_back(ex(0, 0, 0, 0));
        -> async_ev;
        cyc(I_NONE, ex(0, 0, 0, 0), "t6_rst_hold");
        cyc(I_NONE, ex(0, 0, 0, 0), "t6_rst_hold");
        @(negedge CLK_IN);
        RST_IN = 1'b0;
        cyc(I_NONE, ex(0, 0, 0, 0), "t6_idle");
        cyc(I_START, ex(1, 0, 0, 0), "t6_start_after");
        cyc(I_NONE, ex(1, 0, 0, 0), "t6_cr");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK_IN);
        #5;
        if (exp_q.size() > 0 || aexp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size() + aexp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
